// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the instruction cache
// (ic) and the data cache (dc), one transaction at a time, round-robin.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   ic_mem_req_* / dc_mem_req_*   per-cache request, address and write-data channels
//   ic_mem_resp_* / dc_mem_resp_* per-cache read response
//   mem_req_* / mem_resp_*     shared memory-side request and response
//   busy                       arbiter is serving a transaction
//   err_stray_resp             sticky: memory responded with no read pending
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int MASK_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ic_mem_req_valid,
    output logic                 ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0] ic_mem_req_addr,
    input  logic                 ic_mem_req_rw,
    input  logic                 ic_mem_req_data_valid,
    output logic                 ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0] ic_mem_req_data_bits,
    input  logic [MASK_BITS-1:0] ic_mem_req_data_mask,
    output logic                 ic_mem_resp_valid,
    output logic [DATA_BITS-1:0] ic_mem_resp_data,

    input  logic                 dc_mem_req_valid,
    output logic                 dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0] dc_mem_req_addr,
    input  logic                 dc_mem_req_rw,
    input  logic                 dc_mem_req_data_valid,
    output logic                 dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0] dc_mem_req_data_bits,
    input  logic [MASK_BITS-1:0] dc_mem_req_data_mask,
    output logic                 dc_mem_resp_valid,
    output logic [DATA_BITS-1:0] dc_mem_resp_data,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic                 mem_req_rw,
    output logic                 mem_req_data_valid,
    input  logic                 mem_req_data_ready,
    output logic [DATA_BITS-1:0] mem_req_data_bits,
    output logic [MASK_BITS-1:0] mem_req_data_mask,
    input  logic                 mem_resp_valid,
    input  logic [DATA_BITS-1:0] mem_resp_data,

    output logic                 busy,
    output logic                 err_stray_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // owner_dc: 1 = dc owns the port, 0 = ic (only meaningful outside IDLE)
    // ptr_dc:   1 = dc wins the next contested arbitration
    logic owner_dc;
    logic ptr_dc;
    logic addr_done;
    logic data_done;
    logic err_q;

    // Owner view of the request channels
    logic                 own_valid;
    logic                 own_rw;
    logic                 own_dvalid;
    logic [ADDR_BITS-1:0] own_addr;
    logic [DATA_BITS-1:0] own_bits;
    logic [MASK_BITS-1:0] own_mask;

    always_comb begin
        if (owner_dc) begin
            own_valid  = dc_mem_req_valid;
            own_rw     = dc_mem_req_rw;
            own_dvalid = dc_mem_req_data_valid;
            own_addr   = dc_mem_req_addr;
            own_bits   = dc_mem_req_data_bits;
            own_mask   = dc_mem_req_data_mask;
        end else begin
            own_valid  = ic_mem_req_valid;
            own_rw     = ic_mem_req_rw;
            own_dvalid = ic_mem_req_data_valid;
            own_addr   = ic_mem_req_addr;
            own_bits   = ic_mem_req_data_bits;
            own_mask   = ic_mem_req_data_mask;
        end
    end

    logic in_req;
    logic in_resp;
    logic req_rdy;
    logic dat_rdy;
    logic resp_fwd;
    logic a_hs;
    logic d_hs;
    logic a_all;
    logic d_all;

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);

    // Address is issued only once; write data is forwarded until accepted.
    assign mem_req_valid      = in_req & own_valid & ~addr_done;
    assign mem_req_data_valid = in_req & own_dvalid & own_rw & ~data_done;

    // Fields are zero whenever no request phase is active.
    assign mem_req_addr      = in_req ? own_addr : '0;
    assign mem_req_rw        = in_req ? own_rw : 1'b0;
    assign mem_req_data_bits = in_req ? own_bits : '0;
    assign mem_req_data_mask = in_req ? own_mask : '0;

    assign req_rdy = in_req & ~addr_done & mem_req_ready;
    assign dat_rdy = in_req & ~data_done & mem_req_data_ready;

    assign ic_mem_req_ready      = req_rdy & ~owner_dc;
    assign dc_mem_req_ready      = req_rdy & owner_dc;
    assign ic_mem_req_data_ready = dat_rdy & ~owner_dc;
    assign dc_mem_req_data_ready = dat_rdy & owner_dc;

    // Only a response that arrives while waiting for one reaches a cache.
    assign resp_fwd          = in_resp & mem_resp_valid;
    assign ic_mem_resp_valid = resp_fwd & ~owner_dc;
    assign dc_mem_resp_valid = resp_fwd & owner_dc;
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

    assign busy           = (state != IDLE);
    assign err_stray_resp = err_q;

    // Handshakes of this cycle, merged with those already recorded
    assign a_hs  = mem_req_valid & mem_req_ready;
    assign d_hs  = mem_req_data_valid & mem_req_data_ready;
    assign a_all = addr_done | a_hs;
    assign d_all = data_done | d_hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_dc  <= 1'b0;
            ptr_dc    <= 1'b1;
            addr_done <= 1'b0;
            data_done <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (mem_resp_valid && !in_resp)
                err_q <= 1'b1;

            unique case (state)
                IDLE: begin
                    addr_done <= 1'b0;
                    data_done <= 1'b0;
                    if (ic_mem_req_valid || dc_mem_req_valid) begin
                        // dc wins if alone, or if contested and it holds priority
                        owner_dc <= dc_mem_req_valid &
                                    (~ic_mem_req_valid | ptr_dc);
                        state    <= REQ;
                    end
                end

                REQ: begin
                    if (!addr_done && !own_valid) begin
                        // Request withdrawn before issue: priority unchanged
                        state <= IDLE;
                    end else if (!own_rw) begin
                        addr_done <= a_all;
                        if (a_hs)
                            state <= RESP;
                    end else begin
                        addr_done <= a_all;
                        data_done <= d_all;
                        if (a_all && d_all) begin
                            state  <= IDLE;
                            ptr_dc <= ~owner_dc;
                        end
                    end
                end

                RESP: begin
                    if (mem_resp_valid) begin
                        state  <= IDLE;
                        ptr_dc <= ~owner_dc;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model of ownership, priority and response routing.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;

    logic         ic_mem_req_valid, ic_mem_req_ready;
    logic [27:0]  ic_mem_req_addr;
    logic         ic_mem_req_rw;
    logic         ic_mem_req_data_valid, ic_mem_req_data_ready;
    logic [127:0] ic_mem_req_data_bits;
    logic [15:0]  ic_mem_req_data_mask;
    logic         ic_mem_resp_valid;
    logic [127:0] ic_mem_resp_data;

    logic         dc_mem_req_valid, dc_mem_req_ready;
    logic [27:0]  dc_mem_req_addr;
    logic         dc_mem_req_rw;
    logic         dc_mem_req_data_valid, dc_mem_req_data_ready;
    logic [127:0] dc_mem_req_data_bits;
    logic [15:0]  dc_mem_req_data_mask;
    logic         dc_mem_resp_valid;
    logic [127:0] dc_mem_resp_data;

    logic         mem_req_valid, mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         busy, err_stray_resp;

    int vectors = 0;
    int miscompares = 0;
    bit m_ptr_dc;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
        .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
        .ic_mem_req_data_valid(ic_mem_req_data_valid),
        .ic_mem_req_data_ready(ic_mem_req_data_ready),
        .ic_mem_req_data_bits(ic_mem_req_data_bits),
        .ic_mem_req_data_mask(ic_mem_req_data_mask),
        .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
        .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
        .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
        .dc_mem_req_data_valid(dc_mem_req_data_valid),
        .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_req_data_bits(dc_mem_req_data_bits),
        .dc_mem_req_data_mask(dc_mem_req_data_mask),
        .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .err_stray_resp(err_stray_resp)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        ic_mem_req_valid = 1'b0; ic_mem_req_rw = 1'b0;
        ic_mem_req_data_valid = 1'b0; ic_mem_req_addr = '0;
        ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
        dc_mem_req_valid = 1'b0; dc_mem_req_rw = 1'b0;
        dc_mem_req_data_valid = 1'b0; dc_mem_req_addr = '0;
        dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_ptr_dc = 1'b1;
    endtask

    // One full transaction. Called at a negedge with the arbiter idle.
    // a_at / d_at: cycle (from first granted cycle) at which memory accepts
    // the address / write data. rdly: cycles in RESP before the response.
    task automatic txn(input bit ir, input bit dr, input bit irw, input bit drw,
                       input logic [27:0] ia, input logic [27:0] da,
                       input int a_at, input int d_at, input int rdly,
                       input logic [127:0] rdata);
        bit w;
        bit rw;
        int last;
        logic [27:0] ea;
        logic [127:0] ib, db, ed;
        logic [15:0] imk, dmk, em;
        ib = rnd128(); db = rnd128();
        imk = 16'($urandom); dmk = 16'($urandom);
        // Reference: a lone requester wins; a contested grant follows priority
        w = (ir && dr) ? m_ptr_dc : dr;
        rw = w ? drw : irw;
        ea = w ? da : ia;
        ed = w ? db : ib;
        em = w ? dmk : imk;
        ic_mem_req_valid = ir; ic_mem_req_rw = irw; ic_mem_req_addr = ia;
        ic_mem_req_data_valid = 1'b1; ic_mem_req_data_bits = ib;
        ic_mem_req_data_mask = imk;
        dc_mem_req_valid = dr; dc_mem_req_rw = drw; dc_mem_req_addr = da;
        dc_mem_req_data_valid = 1'b1; dc_mem_req_data_bits = db;
        dc_mem_req_data_mask = dmk;
        tick();
        last = rw ? ((a_at > d_at) ? a_at : d_at) : a_at;
        for (int c = 0; c <= last; c++) begin
            mem_req_ready = (c == a_at);
            mem_req_data_ready = rw && (c == d_at);
            #1;
            chk1("busy_req", busy, 1'b1);
            chk1("mem_req_valid", mem_req_valid, c <= a_at);
            chk1("mem_data_valid", mem_req_data_valid, rw && (c <= d_at));
            chk1("own_req_ready", w ? dc_mem_req_ready : ic_mem_req_ready,
                 c == a_at);
            chk1("oth_req_ready", w ? ic_mem_req_ready : dc_mem_req_ready, 1'b0);
            chk1("own_data_ready",
                 w ? dc_mem_req_data_ready : ic_mem_req_data_ready,
                 rw && (c == d_at));
            chk1("oth_data_ready",
                 w ? ic_mem_req_data_ready : dc_mem_req_data_ready, 1'b0);
            if (c == 0) begin
                chkw("mem_req_addr", 128'(mem_req_addr), 128'(ea));
                chk1("mem_req_rw", mem_req_rw, rw);
                chkw("mem_req_bits", mem_req_data_bits, ed);
                chkw("mem_req_mask", 128'(mem_req_data_mask), 128'(em));
            end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_req_data_ready = 1'b0;
        if (!rw) begin
            for (int r = 0; r <= rdly; r++) begin
                mem_req_ready = 1'b1;
                mem_resp_valid = (r == rdly);
                mem_resp_data = rdata;
                #1;
                chk1("busy_resp", busy, 1'b1);
                chk1("resp_no_issue", mem_req_valid, 1'b0);
                chk1("resp_ic_ready", ic_mem_req_ready, 1'b0);
                chk1("resp_dc_ready", dc_mem_req_ready, 1'b0);
                chk1("own_resp_valid", w ? dc_mem_resp_valid : ic_mem_resp_valid,
                     r == rdly);
                chk1("oth_resp_valid", w ? ic_mem_resp_valid : dc_mem_resp_valid,
                     1'b0);
                if (r == rdly)
                    chkw("own_resp_data", w ? dc_mem_resp_data : ic_mem_resp_data,
                         rdata);
                tick();
            end
            mem_resp_valid = 1'b0;
            mem_req_ready = 1'b0;
        end else begin
            chk1("wr_no_ic_resp", ic_mem_resp_valid, 1'b0);
            chk1("wr_no_dc_resp", dc_mem_resp_valid, 1'b0);
        end
        chk1("done_idle", busy, 1'b0);
        ic_mem_req_valid = 1'b0; ic_mem_req_data_valid = 1'b0;
        dc_mem_req_valid = 1'b0; dc_mem_req_data_valid = 1'b0;
        m_ptr_dc = !w;
    endtask

    initial begin
        logic [127:0] dead;
        dead = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        // Reset state
        do_reset();
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_valid", mem_req_valid, 1'b0);
        chk1("rst_mem_dvalid", mem_req_data_valid, 1'b0);
        chkw("rst_addr", 128'(mem_req_addr), 128'd0);
        chkw("rst_bits", mem_req_data_bits, 128'd0);
        chkw("rst_mask", 128'(mem_req_data_mask), 128'd0);
        chk1("rst_err", err_stray_resp, 1'b0);
        chk1("rst_ic_resp", ic_mem_resp_valid, 1'b0);
        chk1("rst_dc_resp", dc_mem_resp_valid, 1'b0);
        tick();

        // dc read alone, response 3 cycles after address handshake
        txn(1'b0, 1'b1, 1'b0, 1'b0, 28'h0, 28'h0000123, 0, 0, 3, dead);

        // Contested reads from reset: dc, ic, dc, ic
        do_reset();
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 1'b0, 1'b0, 28'($urandom), 28'($urandom),
                0, 0, 1, rnd128());

        // dc writes: data 2 cycles after address, then both together
        txn(1'b0, 1'b1, 1'b0, 1'b1, 28'h0, 28'h0000040, 0, 2, 0, '0);
        txn(1'b0, 1'b1, 1'b0, 1'b1, 28'h0, 28'h0000040, 1, 1, 0, '0);
        // Data accepted before the address
        txn(1'b0, 1'b1, 1'b0, 1'b1, 28'h0, 28'h0000080, 2, 0, 0, '0);

        // ic read in RESP while dc presents a write
        ic_mem_req_valid = 1'b1; ic_mem_req_rw = 1'b0;
        ic_mem_req_addr = 28'h0000abc;
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk1("blk_ic_granted", ic_mem_req_ready, 1'b1);
        tick();
        ic_mem_req_valid = 1'b0;
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b1;
        dc_mem_req_data_valid = 1'b1; dc_mem_req_addr = 28'h0000def;
        mem_req_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("blk_busy", busy, 1'b1);
            chk1("blk_dc_ready", dc_mem_req_ready, 1'b0);
            chk1("blk_dc_dready", dc_mem_req_data_ready, 1'b0);
            chk1("blk_mem_valid", mem_req_valid, 1'b0);
            tick();
        end
        mem_resp_valid = 1'b1; mem_resp_data = dead;
        #1;
        chk1("blk_ic_resp", ic_mem_resp_valid, 1'b1);
        chk1("blk_dc_resp", dc_mem_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;
        chk1("blk_idle_gap", busy, 1'b0);
        tick();
        #1;
        chk1("blk_dc_granted", dc_mem_req_ready, 1'b1);
        chk1("blk_dc_dgrant", dc_mem_req_data_ready, 1'b1);
        chkw("blk_dc_addr", 128'(mem_req_addr), 128'h0000def);
        chk1("blk_dc_rw", mem_req_rw, 1'b1);
        tick();
        chk1("blk_wr_done", busy, 1'b0);
        quiet();
        m_ptr_dc = 1'b0;

        // Stray response while idle
        mem_resp_valid = 1'b1; mem_resp_data = rnd128();
        #1;
        chk1("stray_ic_resp", ic_mem_resp_valid, 1'b0);
        chk1("stray_dc_resp", dc_mem_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk1("stray_err", err_stray_resp, 1'b1);
        tick();
        tick();
        chk1("stray_sticky", err_stray_resp, 1'b1);

        // ic withdraws before the address handshake: priority unchanged
        ic_mem_req_valid = 1'b1; ic_mem_req_rw = 1'b0;
        tick();
        chk1("abandon_busy", busy, 1'b1);
        chk1("abandon_valid", mem_req_valid, 1'b1);
        ic_mem_req_valid = 1'b0;
        #1;
        chk1("abandon_drop", mem_req_valid, 1'b0);
        tick();
        chk1("abandon_idle", busy, 1'b0);
        txn(1'b1, 1'b1, 1'b0, 1'b1, 28'($urandom), 28'($urandom), 0, 0, 0,
            rnd128());

        // Reset while stalled in REQ
        dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b0;
        dc_mem_req_addr = 28'h1234567;
        tick();
        chk1("mid_busy", busy, 1'b1);
        chk1("mid_valid", mem_req_valid, 1'b1);
        reset = 1'b1;
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_valid", mem_req_valid, 1'b0);
        chk1("mid_rst_ready", dc_mem_req_ready, 1'b0);
        chkw("mid_rst_addr", 128'(mem_req_addr), 128'd0);
        chk1("mid_rst_err", err_stray_resp, 1'b0);
        reset = 1'b0;
        quiet();
        m_ptr_dc = 1'b1;
        tick();
        txn(1'b1, 1'b1, 1'b1, 1'b0, 28'($urandom), 28'($urandom), 1, 0, 2,
            rnd128());

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            txn(pat[0], pat[1], 1'($urandom), 1'($urandom),
                28'($urandom), 28'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), rnd128());
        end
        chk1("final_no_err", err_stray_resp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory request/response port between the instruction cache (ic) and the data cache (dc).
- Sits between the two cache instances and the memory model/controller.
- Grants one cache at a time, holds ownership for a whole transaction, and routes the read response back to the owner only.
- One outstanding memory transaction at a time; round-robin fairness between the two caches.

Parameters:
ADDR_BITS, 28, memory line address width (CPU_ADDR_BITS minus log2 of the line size in bytes)
DATA_BITS, 128, memory data width (MEM_DATA_BITS)
MASK_BITS, 16, byte mask width (DATA_BITS/8)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
ic_mem_req_valid / dc_mem_req_valid  in  1  cache requests a memory transaction
ic_mem_req_ready / dc_mem_req_ready  out  1  address handshake accepted (owner only)
ic_mem_req_addr / dc_mem_req_addr  in  ADDR_BITS  line address
ic_mem_req_rw / dc_mem_req_rw  in  1  1 = write, 0 = read
ic_mem_req_data_valid / dc_mem_req_data_valid  in  1  write data present
ic_mem_req_data_ready / dc_mem_req_data_ready  out  1  write data accepted (owner only)
ic_mem_req_data_bits / dc_mem_req_data_bits  in  DATA_BITS  write data
ic_mem_req_data_mask / dc_mem_req_data_mask  in  MASK_BITS  byte mask
ic_mem_resp_valid / dc_mem_resp_valid  out  1  read data valid for this cache
ic_mem_resp_data / dc_mem_resp_data  out  DATA_BITS  mem_resp_data passed through unconditionally
mem_req_valid  out  1  to memory
mem_req_ready  in  1  from memory
mem_req_addr  out  ADDR_BITS  owner address
mem_req_rw  out  1  owner rw
mem_req_data_valid  out  1  owner data_valid, gated
mem_req_data_ready  in  1  from memory
mem_req_data_bits  out  DATA_BITS  owner data
mem_req_data_mask  out  MASK_BITS  owner mask
mem_resp_valid  in  1  memory read response
mem_resp_data  in  DATA_BITS  memory read data
busy  out  1  state != IDLE
err_stray_resp  out  1  sticky; mem_resp_valid seen outside RESP

Behaviour:
- Reset (synchronous):
  - State IDLE; owner = none; priority pointer = dc.
  - Clear addr_done and data_done; clear err_stray_resp.
  - All valid/ready outputs 0. Address, data and mask outputs 0 when no owner.
- State IDLE:
  - No outputs asserted.
  - If exactly one cache asserts req_valid, latch it as owner.
  - If both assert req_valid, latch the cache named by the priority pointer.
  - Next state REQ. Arbitration latency is 1 cycle.
- State REQ:
  - mem_req_valid = owner req_valid. mem_req_addr, mem_req_rw, mem_req_data_bits and mem_req_data_mask = owner signals.
  - mem_req_data_valid = owner data_valid AND owner rw.
  - Owner req_ready = mem_req_ready; owner data_ready = mem_req_data_ready.
  - Non-owner ready signals are 0 at all times.
  - Address handshake (valid & ready) sets addr_done. Write-data handshake sets data_done. Both may occur in the same cycle, in either order.
  - Read: on the address handshake cycle, go to RESP.
  - Write: when addr_done and data_done are both true (counting the current cycle's handshakes), complete. Go to IDLE and toggle the priority pointer away from the owner.
  - Once addr_done is set, the arbiter keeps mem_req_valid low so the address is not reissued. Write data continues to be forwarded until data_done.
  - Owner drops req_valid before the address handshake: abandon, return to IDLE, pointer unchanged.
- State RESP:
  - All requests blocked; no ready to either cache.
  - On mem_resp_valid, pulse owner resp_valid for exactly that cycle; the non-owner's resp_valid stays 0.
  - Then go to IDLE and toggle the priority pointer.
  - No timeout: RESP waits indefinitely.
- mem_resp_valid in IDLE or REQ: not forwarded to either cache; err_stray_resp set until reset.
- Fairness: with both caches continuously requesting, grants alternate ic/dc. After reset the first contested grant goes to dc.
- Back-to-back: transaction completion returns to IDLE, so the minimum gap is 1 idle cycle between transactions.
- Reset asserted mid-transaction: immediate return to IDLE. Any in-flight memory response afterwards counts as stray.

Test Plan:
- Reset, then dc read alone at addr 0x0000123, memory ready immediately, response data 0xDEADBEEF_... 3 cycles later -> mem_req_valid 1 cycle after request; dc_mem_resp_valid 1 cycle with that data; ic_mem_resp_valid stays 0; busy falls next cycle.
- ic and dc request reads together, 4 times back-to-back -> grant order dc, ic, dc, ic; non-owner ready stays 0 throughout.
- dc write, addr 0x0000040, mask 16'hFFFF: data handshake 2 cycles after the address handshake, then a second write with both handshakes in the same cycle -> each write completes exactly once; no resp_valid; IDLE after both handshakes.
- ic read pending in RESP while dc asserts a write -> dc is not granted until ic's response arrives; dc is then granted on the next arbitration.
- mem_resp_valid pulsed while IDLE -> no cache resp_valid; err_stray_resp = 1 until reset.
- Reset asserted in REQ with mem_req_ready held 0 -> next cycle all outputs 0, state IDLE; a following contested request is granted to dc.
